// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - captures audio samples into a frame buffer and streams one frame to the FFT input
//
// Purpose: collects FRAME_LEN signed audio samples (optionally zero-padded after a
// flush) and replays them as one AXI-Stream frame, beat k = buffer[k], tlast on the
// final beat.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   audio_valid_in, audio_in  sample strobe and signed sample
//   flush_in                  end capture early; the rest of the frame is zero-filled
//   m_axis_data_*             master stream to the FFT: tdata = {16'h0, audio, 8'h00}
//   busy_out                  high whenever the block is not idle
//   frame_done_out            one-cycle pulse after the tlast beat is accepted
//   dropped_out               saturating count of samples discarded while streaming

module fft_frame_streamer #(
  parameter int FRAME_LEN    = 2048,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    audio_valid_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  input  logic                    flush_in,
  input  logic                    m_axis_data_tready,
  output logic                    m_axis_data_tvalid,
  output logic [31:0]             m_axis_data_tdata,
  output logic                    m_axis_data_tlast,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic [15:0]             dropped_out
);

  localparam int              AW        = $clog2(FRAME_LEN);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_PAD    = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]              state;
  logic [AW-1:0]           wr_addr;
  logic [AW-1:0]           rd_addr;
  logic                    rd_done;
  logic [SAMPLE_WIDTH-1:0] buffer [FRAME_LEN];

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [SAMPLE_WIDTH-1:0] wdata;
  logic [15:0]             rd_real;
  logic                    last_accept;
  logic                    load;

  assign busy_out = (state != S_IDLE);

  // Sample sits in the top bits of the 16-bit real half; the imaginary half stays zero.
  assign rd_real = 16'(buffer[rd_addr]) << (16 - SAMPLE_WIDTH);

  assign last_accept = m_axis_data_tvalid & m_axis_data_tready & m_axis_data_tlast;

  // The output register doubles as the read-data register: it refills whenever it is
  // empty or its beat is being taken, so tready stalls the prefetch without skipping.
  assign load = (state == S_STREAM) && !rd_done &&
                (!m_axis_data_tvalid || m_axis_data_tready);

  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = audio_in;
    case (state)
      S_IDLE: begin
        we    = audio_valid_in;
        waddr = '0;
      end
      S_FILL: we = audio_valid_in;
      S_PAD: begin
        we    = 1'b1;
        wdata = '0;
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      buffer[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= S_IDLE;
      wr_addr            <= '0;
      rd_addr            <= '0;
      rd_done            <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tlast  <= 1'b0;
      frame_done_out     <= 1'b0;
      dropped_out        <= '0;
    end else begin
      frame_done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (audio_valid_in) begin
            wr_addr <= AW'(1);
            state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (audio_valid_in) begin
            wr_addr <= wr_addr + 1'b1;
            // A sample that completes the frame wins over a simultaneous flush.
            if (wr_addr == LAST_ADDR) begin
              state <= S_STREAM;
            end else if (flush_in) begin
              state <= S_PAD;
            end
          end else if (flush_in) begin
            state <= S_PAD;
          end
        end
        S_PAD: begin
          wr_addr <= wr_addr + 1'b1;
          if (wr_addr == LAST_ADDR) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (audio_valid_in && (dropped_out != 16'hFFFF)) begin
            dropped_out <= dropped_out + 16'd1;
          end
          if (last_accept) begin
            state              <= S_IDLE;
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tlast  <= 1'b0;
            frame_done_out     <= 1'b1;
            rd_addr            <= '0;
            rd_done            <= 1'b0;
          end else if (load) begin
            m_axis_data_tvalid <= 1'b1;
            m_axis_data_tdata  <= {16'h0000, rd_real};
            m_axis_data_tlast  <= (rd_addr == LAST_ADDR);
            rd_addr            <= rd_addr + 1'b1;
            if (rd_addr == LAST_ADDR) begin
              rd_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb/tb_fft_frame_streamer.sv - directed self-checking bench for fft_frame_streamer

module tb_fft_frame_streamer;

  localparam int FRAME_LEN = 2048;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        audio_valid_in;
  logic [7:0]  audio_in;
  logic        flush_in;
  logic        m_axis_data_tready;
  logic        m_axis_data_tvalid;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tlast;
  logic        busy_out;
  logic        frame_done_out;
  logic [15:0] dropped_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] samp [FRAME_LEN];

  fft_frame_streamer #(
    .FRAME_LEN    (FRAME_LEN),
    .SAMPLE_WIDTH (8)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .audio_valid_in     (audio_valid_in),
    .audio_in           (audio_in),
    .flush_in           (flush_in),
    .m_axis_data_tready (m_axis_data_tready),
    .m_axis_data_tvalid (m_axis_data_tvalid),
    .m_axis_data_tdata  (m_axis_data_tdata),
    .m_axis_data_tlast  (m_axis_data_tlast),
    .busy_out           (busy_out),
    .frame_done_out     (frame_done_out),
    .dropped_out        (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input int k);
    return {16'h0000, samp[k], 8'h00};
  endfunction

  task automatic fill(input int n);
    for (int k = 0; k < n; k++) begin
      audio_valid_in = 1'b1;
      audio_in       = samp[k];
      step();
    end
    audio_valid_in = 1'b0;
  endtask

  // Runs from the cycle after the last capture write until the frame_done cycle.
  task automatic stream_frame(input string tag, input bit bp, input int drops, input int exp_lat);
    int          cyc, idx, errs, first_v;
    bit          hold, done;
    logic [31:0] pd, last_data;
    logic        pl;
    cyc = 0; idx = 0; errs = 0; first_v = -1;
    hold = 0; done = 0; pd = '0; pl = 1'b0; last_data = '0;
    while (!done && cyc < 20000) begin
      m_axis_data_tready = (bp && ($urandom_range(0, 1) == 0)) ? 1'b0 : 1'b1;
      audio_valid_in     = (cyc >= 10 && cyc < 10 + drops);
      audio_in           = 8'h55;
      if (hold && (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== pd ||
                   m_axis_data_tlast !== pl)) errs++;
      if (frame_done_out !== 1'b0) errs++;
      if (busy_out !== 1'b1) errs++;
      if (m_axis_data_tvalid === 1'b1 && first_v < 0) first_v = cyc;
      if (m_axis_data_tvalid === 1'b1 && m_axis_data_tready) begin
        if (idx < FRAME_LEN) begin
          if (m_axis_data_tdata !== exp_beat(idx)) errs++;
          if (m_axis_data_tlast !== (idx == FRAME_LEN - 1)) errs++;
        end else begin
          errs++;
        end
        last_data = m_axis_data_tdata;
        idx++;
        if (m_axis_data_tlast === 1'b1) done = 1;
      end
      hold = (m_axis_data_tvalid === 1'b1) && !m_axis_data_tready;
      pd   = m_axis_data_tdata;
      pl   = m_axis_data_tlast;
      step();
      cyc++;
    end
    audio_valid_in     = 1'b0;
    m_axis_data_tready = 1'b1;
    check({tag, "_beats"}, idx, FRAME_LEN);
    check({tag, "_errs"}, errs, 0);
    check({tag, "_latency"}, first_v, exp_lat);
    check({tag, "_last_data"}, last_data, exp_beat(FRAME_LEN - 1));
    check({tag, "_done_pulse"}, frame_done_out, 1'b1);
    check({tag, "_busy_done"}, busy_out, 1'b0);
    check({tag, "_tvalid_done"}, m_axis_data_tvalid, 1'b0);
  endtask

  initial begin
    int cyc, idx;
    rst_in = 1'b1; audio_valid_in = 1'b0; audio_in = '0;
    flush_in = 1'b0; m_axis_data_tready = 1'b1;
    step(); step();
    check("rst_tvalid", m_axis_data_tvalid, 1'b0);
    check("rst_tdata", m_axis_data_tdata, 32'h0);
    check("rst_tlast", m_axis_data_tlast, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", frame_done_out, 1'b0);
    check("rst_dropped", dropped_out, 16'h0);
    rst_in = 1'b0;
    step();

    flush_in = 1'b1; step(); flush_in = 1'b0;
    check("idle_flush_busy", busy_out, 1'b0);

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = k[7:0];
    fill(FRAME_LEN);
    stream_frame("nominal", 0, 0, 1);
    check("nominal_dropped", dropped_out, 16'h0);

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = 8'(k * 7 + 3);
    fill(FRAME_LEN);
    stream_frame("backpressure", 1, 0, 1);

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = (k < 100) ? 8'h7F : 8'h00;
    fill(100);
    flush_in = 1'b1; step(); flush_in = 1'b0;
    check("pad_busy", busy_out, 1'b1);
    stream_frame("flush", 0, 5, 1949);
    check("pad_no_drop_count", dropped_out, 16'h0);

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = k[7:0];
    samp[FRAME_LEN - 1] = 8'h80;
    fill(FRAME_LEN - 1);
    audio_valid_in = 1'b1; audio_in = 8'h80; flush_in = 1'b1;
    step();
    audio_valid_in = 1'b0; flush_in = 1'b0;
    stream_frame("simul", 0, 0, 1);

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = ~k[7:0];
    fill(FRAME_LEN);
    stream_frame("overrun", 0, 5, 1);
    check("overrun_dropped", dropped_out, 16'd5);

    // Next capture begins in the frame_done cycle itself.
    for (int k = 0; k < FRAME_LEN; k++) samp[k] = 8'(k * 3);
    fill(FRAME_LEN);
    m_axis_data_tready = 1'b1;
    cyc = 0; idx = 0;
    while (cyc < 5000 && !(m_axis_data_tvalid === 1'b1 && idx == 1000)) begin
      if (m_axis_data_tvalid === 1'b1) idx++;
      step();
      cyc++;
    end
    check("rst_reach_beat", idx, 1000);
    check("rst_beat1000_data", m_axis_data_tdata, exp_beat(1000));
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("midrst_tvalid", m_axis_data_tvalid, 1'b0);
    check("midrst_busy", busy_out, 1'b0);
    check("midrst_tlast", m_axis_data_tlast, 1'b0);
    check("midrst_dropped", dropped_out, 16'h0);
    step();

    for (int k = 0; k < FRAME_LEN; k++) samp[k] = k[7:0] ^ 8'hA5;
    fill(FRAME_LEN);
    stream_frame("post_reset", 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
# fft_frame_streamer

Master-side feeder for the FFT core's input AXI-Stream port. Captures 8-bit signed audio samples (12 kHz valid strobes) into an on-chip frame buffer, then streams one complete frame of FRAME_LEN samples to the FFT with correct tvalid/tlast/tready handshaking. It replaces ad-hoc driving of fft_valid/fft_data/fft_last. It sits between the recorder/microphone path and the FFT core, which in turn feeds tone_detection_fsm.

## Interface
- FRAME_LEN, 2048: samples per FFT frame; power of two.
- SAMPLE_WIDTH, 8: audio sample width, signed.
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous, active-high reset.
- audio_valid_in  input  1  single-cycle strobe; audio_in is valid this cycle.
- audio_in  input  SAMPLE_WIDTH  signed audio sample.
- flush_in  input  1  single-cycle pulse: end capture early, zero-pad the rest of the frame.
- m_axis_data_tready  input  1  FFT core ready.
- m_axis_data_tvalid  output  1  sample valid to FFT.
- m_axis_data_tdata  output  32  [15:0] real = {audio, 8'b0}; [31:16] imaginary = 0.
- m_axis_data_tlast  output  1  high on the sample with index FRAME_LEN-1.
- busy_out  output  1  high in any state other than IDLE.
- frame_done_out  output  1  one-cycle pulse after the tlast beat is accepted.
- dropped_out  output  16  saturating count of audio_valid_in strobes ignored during streaming.

## Operation
- States: IDLE, FILL, PAD, STREAM.
- IDLE → FILL on the first audio_valid_in. That sample is written to address 0.
- FILL:
  - Each audio_valid_in writes audio_in at wr_addr, then increments wr_addr.
  - Writing address FRAME_LEN-1 → STREAM.
  - flush_in with wr_addr < FRAME_LEN → PAD.
- PAD: writes zero at one address per cycle until address FRAME_LEN-1 is written, then → STREAM. audio_valid_in is ignored here and not counted.
- STREAM:
  - Buffer read with 1-cycle registered read latency, prefetched into a single output register.
  - Beat k carries buffer[k]; tlast = (k == FRAME_LEN-1).
  - When the tlast beat is accepted → IDLE, and frame_done_out pulses on the next cycle.
- audio_valid_in during STREAM: the sample is discarded and dropped_out increments, saturating at 16'hFFFF. dropped_out clears only on rst_in.
- flush_in in IDLE or STREAM: ignored.
- flush_in and audio_valid_in in the same FILL cycle: write the sample first, then PAD from the next address. If that sample lands at FRAME_LEN-1, go to STREAM; no pad is needed.
- Sign handling: tdata[15:8] = audio_in, tdata[7:0] = 0, tdata[31:16] = 0. The sample is not sign-extended into the imaginary half.
- Address counters are $clog2(FRAME_LEN) bits wide and wrap to 0 at frame end.

## Timing
- Reset values: tvalid=0, tdata=0, tlast=0, busy_out=0, frame_done_out=0, dropped_out=0. State=IDLE, addresses=0.
- Reset mid-frame: the frame is abandoned and tvalid drops on the cycle after rst_in is sampled. No partial tlast is ever emitted.
- Fill-to-stream latency:
  - The last buffer write (or last pad write) occurs in cycle N.
  - The STREAM read is issued in N+1.
  - tvalid=1 with beat 0 in cycle N+2.
- AXI rules:
  - Once tvalid=1, tvalid, tdata and tlast hold until the cycle tready=1.
  - tvalid never depends combinationally on tready.
  - Beat accepted = tvalid & tready at the rising edge.
- Throughput: with tready held high, one beat per cycle. Exactly FRAME_LEN consecutive beats, beat 0 → beat FRAME_LEN-1.
- tready deasserted mid-frame: the current beat is held and the prefetch is stalled. No beat is skipped or duplicated on resume.
- frame_done_out is high exactly 1 cycle: the cycle after tlast acceptance. busy_out is 0 in that same cycle.
- Back-to-back frames: an audio_valid_in in the frame_done_out cycle starts the next FILL at address 0.

## Test plan
- Nominal frame:
  - Stimulus: FRAME_LEN strobes with audio_in = index[7:0], tready tied 1.
  - Required: tvalid rises 2 cycles after the last write; 2048 consecutive beats; beat k tdata = {16'h0, k[7:0], 8'h00}; tlast only on beat 2047; frame_done_out 1 cycle later.
- Backpressure:
  - Stimulus: tready toggles with a random ~50% duty during STREAM.
  - Required: the accepted beat sequence is identical to the nominal case; tdata and tlast are stable while tvalid & !tready.
- Flush / zero-pad:
  - Stimulus: 100 samples of 8'h7F, then flush_in.
  - Required: beats 0–99 tdata = 32'h00007F00; beats 100–2047 tdata = 0; tlast on beat 2047.
- Overrun:
  - Stimulus: 5 audio_valid_in strobes during STREAM.
  - Required: dropped_out = 5; streamed data unchanged; the next frame starts only after frame_done_out.
- Mid-stream reset:
  - Stimulus: rst_in at beat 1000.
  - Required: next cycle tvalid=0 and busy_out=0; a new full frame afterwards streams correctly from beat 0.
- Simultaneous flush and sample:
  - Stimulus: sample 8'h80 with flush_in at wr_addr 2047.
  - Required: no PAD state entered; beat 2047 tdata = 32'h00008000 with tlast=1.
